// File: rtl/div_pkg.sv
// Shared types and constants for the divider arbiter and its round-robin picker.
// Also fixes the result pattern returned for a zero divisor.
package div_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_START   = 4'd1,
    ST_WAIT    = 4'd2,
    ST_ABORT   = 4'd3,
    ST_RESPOND = 4'd4
  } arb_state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  // A zero divisor answers with an all-ones quotient, remainder = dividend, err set.
  localparam logic ZDIV_Q_FILL = 1'b1;
  localparam logic ZDIV_ERR    = 1'b1;

endpackage

// File: rtl/div_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// No state; the caller owns and advances the pointer.
module div_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             any
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (!any && req_valid[idx]) begin
        any       = 1'b1;
        gnt_idx   = idx;
        gnt[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one divider core: one transaction in flight,
// divide-by-zero short-circuit, and a watchdog that resets a hung core.
module div_arbiter
  import div_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_dividend,
  input  logic [N_REQ*WIDTH-1:0] req_divisor,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_quotient,
  output logic [WIDTH-1:0]       rsp_remainder,
  output logic                   rsp_err,
  output logic                   div_rst_n,
  output logic                   div_start,
  output logic [WIDTH-1:0]       div_dividend,
  output logic [WIDTH-1:0]       div_divisor,
  input  logic                   div_stop,
  input  logic [WIDTH-1:0]       div_quotient,
  input  logic [WIDTH-1:0]       div_remainder
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic [N_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [WIDTH-1:0] rsp_quo_q, rsp_quo_d;
  logic [WIDTH-1:0] rsp_rem_q, rsp_rem_d;
  logic             rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] pick_a, pick_b;

  div_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .gnt       (pick_gnt),
    .gnt_idx   (pick_idx),
    .any       (pick_any)
  );

  assign pick_a    = req_dividend[pick_idx*WIDTH +: WIDTH];
  assign pick_b    = req_divisor[pick_idx*WIDTH +: WIDTH];
  assign req_ready = (state_q == ST_IDLE && !rst) ? pick_gnt : '0;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gidx_d       = gidx_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    cnt_d        = cnt_q;
    start_d      = 1'b0;
    core_rst_n_d = 1'b1;
    rsp_vld_d    = '0;
    rsp_quo_d    = rsp_quo_q;
    rsp_rem_d    = rsp_rem_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gidx_d  = pick_idx;
          opa_d   = pick_a;
          opb_d   = pick_b;
          // Start is registered, so the zero check is made on the live operand here.
          start_d = (pick_b != '0);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (opb_q == '0) begin
          rsp_err_d         = ZDIV_ERR;
          rsp_quo_d         = {WIDTH{ZDIV_Q_FILL}};
          rsp_rem_d         = opa_q;
          rsp_vld_d[gidx_q] = 1'b1;
          state_d           = ST_RESPOND;
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (div_stop) begin
          rsp_err_d         = 1'b0;
          rsp_quo_d         = div_quotient;
          rsp_rem_d         = div_remainder;
          rsp_vld_d[gidx_q] = 1'b1;
          state_d           = ST_RESPOND;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          core_rst_n_d = 1'b0;
          state_d      = ST_ABORT;
        end
      end
      ST_ABORT: begin
        rsp_err_d         = 1'b1;
        rsp_quo_d         = '0;
        rsp_rem_d         = '0;
        rsp_vld_d[gidx_q] = 1'b1;
        state_d           = ST_RESPOND;
      end
      ST_RESPOND: begin
        ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gidx_q       <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      core_rst_n_q <= 1'b1;
      rsp_vld_q    <= '0;
      rsp_quo_q    <= '0;
      rsp_rem_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gidx_q       <= gidx_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      core_rst_n_q <= core_rst_n_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_quo_q    <= rsp_quo_d;
      rsp_rem_q    <= rsp_rem_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // The core stays in reset for the whole time rst is high, not just after the first edge.
  assign div_rst_n     = core_rst_n_q & ~rst;
  assign div_start     = start_q;
  assign div_dividend  = opa_q;
  assign div_divisor   = opb_q;
  assign rsp_valid     = rsp_vld_q;
  assign rsp_quotient  = rsp_quo_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed vector table, fairness/reset sequences, and
// randomized traffic against a transaction-level reference model.
module tb_div_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_dividend;
  logic [N*W-1:0] req_divisor;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_quotient;
  logic [W-1:0]   rsp_remainder;
  logic           rsp_err;
  logic           div_rst_n;
  logic           div_start;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_divisor;
  logic           div_stop;
  logic [W-1:0]   div_quotient;
  logic [W-1:0]   div_remainder;

  div_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_err       (rsp_err),
    .div_rst_n     (div_rst_n),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_stop      (div_stop),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         c;
    logic [3:0] v;
    logic [7:0] q;
    logic [7:0] r;
    logic       e;
  } rsp_t;

  rsp_t rsp_q[$];
  int   start_cnt = 0, last_start = -1;
  int   rstn_low_cnt = 0, last_rstn_low = -1;
  int   div_lat = 1;
  bit   div_hang = 1'b0;
  int   gq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: responses, start pulses and core-reset pulses, stamped with the cycle number.
  initial forever begin
    @(negedge clk);
    if (rsp_valid != '0) rsp_q.push_back('{cyc, rsp_valid, rsp_quotient, rsp_remainder, rsp_err});
    if (div_start) begin
      start_cnt++;
      last_start = cyc;
    end
    if (!div_rst_n && !rst) begin
      rstn_low_cnt++;
      last_rstn_low = cyc;
    end
  end

  // Divider core model: stop pulse div_lat cycles after start, or never when hung.
  initial begin
    int cd;
    bit busy;
    logic [7:0] mq, mr;
    busy = 1'b0; cd = 0; mq = '0; mr = '0;
    div_stop = 1'b0; div_quotient = '0; div_remainder = '0;
    forever begin
      @(negedge clk);
      div_stop = 1'b0;
      if (!div_rst_n) busy = 1'b0;
      else if (busy) begin
        cd--;
        if (cd == 0) begin
          div_stop = 1'b1; div_quotient = mq; div_remainder = mr; busy = 1'b0;
        end
      end
      if (div_start && div_rst_n && !div_hang) begin
        busy = 1'b1; cd = div_lat;
        mq = (div_divisor == 0) ? 8'hFF : div_dividend / div_divisor;
        mr = (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  function automatic int rr_ref(input logic [3:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int low_idx(input logic [3:0] m);
    for (int k = 0; k < N; k++) if (m[k]) return k;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rsp_q.delete();
  endtask

  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, output int t);
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
    req_valid[i]           = 1'b1;
    t = -1;
    for (int k = 0; k < 300 && t < 0; k++) begin
      #1;
      if (req_ready[i]) t = cyc;
      else @(negedge clk);
    end
    @(negedge clk);
    req_valid[i] = 1'b0;
    chk("grant_wait", (t >= 0), 1);
  endtask

  task automatic wait_rsp(output rsp_t r);
    bit ok;
    ok = 1'b0;
    r  = '{-1, 4'h0, 8'h0, 8'h0, 1'b0};
    for (int k = 0; k < 400 && !ok; k++) begin
      if (rsp_q.size() > 0) begin
        r  = rsp_q.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk);
        #2;
      end
    end
    chk("rsp_wait", ok, 1);
  endtask

  // Hold the current req_valid mask until n grants are seen, then drop all requests.
  task automatic collect(input int n);
    gq.delete();
    for (int k = 0; k < 400 && gq.size() < n; k++) begin
      #1;
      if (req_ready != '0) gq.push_back(low_idx(req_ready));
      @(negedge clk);
    end
    req_valid = '0;
    chk("grant_collect", gq.size(), n);
  endtask

  typedef struct {
    int req; int a; int b; int lat; bit hang;
    int eq; int er; bit ee; int dly;
  } vec_t;

  vec_t vt[9];
  rsp_t r;
  int   t, s0, r0, ptr_m, g, acc;
  bit   tmo;
  logic [7:0] fa[4], fb[4];

  initial begin
    vt[0] = '{1, 100,  7,  3, 1'b0,  14,  2, 1'b0,  5};
    vt[1] = '{2,  55,  0,  3, 1'b0, 255, 55, 1'b1,  2};
    vt[2] = '{0, 255,  1,  1, 1'b0, 255,  0, 1'b0,  3};
    vt[3] = '{3,   7,  9,  5, 1'b0,   0,  7, 1'b0,  7};
    vt[4] = '{2, 200, 16,  2, 1'b0,  12,  8, 1'b0,  4};
    vt[5] = '{0,  10,  3,  0, 1'b1,   0,  0, 1'b1, 67};
    vt[6] = '{1,   9,  3,  1, 1'b0,   3,  0, 1'b0,  3};
    vt[7] = '{3,  77,  5, 64, 1'b0,  15,  2, 1'b0, 66};
    vt[8] = '{2,  90,  4, 65, 1'b0,   0,  0, 1'b1, 67};

    rst = 1'b1;
    req_valid = '1;
    req_dividend = '0;
    req_divisor = '0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_quotient", rsp_quotient, 0);
    chk("reset_rsp_remainder", rsp_remainder, 0);
    chk("reset_div_start", div_start, 0);
    chk("reset_div_dividend", div_dividend, 0);
    chk("reset_div_divisor", div_divisor, 0);
    chk("reset_div_rst_n", div_rst_n, 0);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    rsp_q.delete();

    foreach (vt[i]) begin
      div_lat = vt[i].lat; div_hang = vt[i].hang;
      s0 = start_cnt; r0 = rstn_low_cnt;
      issue(vt[i].req, 8'(vt[i].a), 8'(vt[i].b), t);
      wait_rsp(r);
      chk("vec_rsp_cycle", r.c - t, vt[i].dly);
      chk("vec_rsp_onehot", r.v, 1 << vt[i].req);
      chk("vec_quotient", r.q, vt[i].eq);
      chk("vec_remainder", r.r, vt[i].er);
      chk("vec_err", r.e, vt[i].ee);
      chk("vec_start_count", start_cnt - s0, (vt[i].b != 0));
      if (vt[i].b != 0) chk("vec_start_cycle", last_start - t, 1);
      tmo = vt[i].hang || (vt[i].lat > TO);
      chk("vec_abort_pulses", rstn_low_cnt - r0, tmo);
      if (tmo) chk("vec_abort_cycle", last_rstn_low - t, TO + 2);
      repeat (2) @(negedge clk);
      div_hang = 1'b0;
    end

    // Fairness: all four held high from ptr=0.
    do_reset();
    div_lat = 2;
    for (int i = 0; i < N; i++) begin
      fa[i] = 8'(20 + 13 * i); fb[i] = 8'(i + 2);
      req_dividend[i*W +: W] = fa[i];
      req_divisor[i*W +: W]  = fb[i];
    end
    req_valid = '1;
    collect(5);
    ptr_m = 0;
    for (int k = 0; k < gq.size(); k++) begin
      g = rr_ref(4'hF, ptr_m);
      chk("fair_grant", gq[k], g);
      wait_rsp(r);
      chk("fair_rsp_onehot", r.v, 1 << g);
      chk("fair_quotient", r.q, fa[g] / fb[g]);
      chk("fair_remainder", r.r, fa[g] % fb[g]);
      chk("fair_err", r.e, 0);
      ptr_m = (g + 1) % N;
    end
    repeat (3) @(negedge clk);

    // Reset mid-WAIT with ptr moved to 3 beforehand.
    do_reset();
    div_lat = 2;
    issue(2, 8'd50, 8'd5, t);
    wait_rsp(r);
    chk("pre_reset_quotient", r.q, 10);
    repeat (2) @(negedge clk);
    div_lat = 30;
    issue(0, 8'd60, 8'd7, t);
    repeat (5) @(negedge clk);
    s0 = start_cnt;
    rst = 1'b1;
    #1;
    chk("midreset_div_rst_n", div_rst_n, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midreset_rsp_valid", rsp_valid, 0);
    repeat (40) @(negedge clk);
    chk("midreset_no_rsp", rsp_q.size(), 0);
    chk("midreset_no_start", start_cnt - s0, 0);
    div_lat = 3;
    req_dividend[1*W +: W] = 8'd99;  req_divisor[1*W +: W] = 8'd10;
    req_dividend[3*W +: W] = 8'd123; req_divisor[3*W +: W] = 8'd11;
    req_valid = 4'b1010;
    collect(2);
    if (gq.size() == 2) begin
      chk("midreset_ptr_grant0", gq[0], 1);
      chk("midreset_ptr_grant1", gq[1], 3);
    end
    wait_rsp(r);
    chk("midreset_r1_onehot", r.v, 4'b0010);
    wait_rsp(r);
    chk("midreset_r3_onehot", r.v, 4'b1000);
    chk("midreset_r3_quotient", r.q, 11);
    chk("midreset_r3_remainder", r.r, 2);
    chk("midreset_r3_err", r.e, 0);
    repeat (3) @(negedge clk);

    // Randomized traffic against a transaction-level model.
    begin
      bit         pend[4];
      logic [7:0] pa[4], pb[4];
      rsp_t       expq[$];
      rsp_t       e;
      do_reset();
      ptr_m = 0; acc = -1;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int c = 0; c < 2500; c++) begin
        @(negedge clk);
        #2;
        while (rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          chk("rand_rsp_expected", expq.size() > 0, 1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("rand_rsp_onehot", r.v, e.v);
            chk("rand_quotient", r.q, e.q);
            chk("rand_remainder", r.r, e.r);
            chk("rand_err", r.e, e.e);
          end
        end
        if (acc >= 0) begin
          req_valid[acc] = 1'b0; pend[acc] = 1'b0; acc = -1;
        end
        for (int i = 0; i < N; i++) begin
          if (!pend[i] && $urandom_range(3) == 0) begin
            pa[i] = 8'($urandom_range(255));
            pb[i] = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
            pend[i] = 1'b1;
            req_dividend[i*W +: W] = pa[i];
            req_divisor[i*W +: W]  = pb[i];
            req_valid[i] = 1'b1;
          end
        end
        #1;
        if (req_ready != '0) begin
          g = low_idx(req_ready);
          chk("rand_ready_onehot", $countones(req_ready), 1);
          chk("rand_grant", g, rr_ref(req_valid, ptr_m));
          chk("rand_single_inflight", expq.size(), 0);
          if (pb[g] == 0) expq.push_back('{0, 4'(1 << g), 8'hFF, pa[g], 1'b1});
          else            expq.push_back('{0, 4'(1 << g), pa[g] / pb[g], pa[g] % pb[g], 1'b0});
          ptr_m = (g + 1) % N;
          acc = g;
          div_lat = $urandom_range(8, 1);
        end
      end
      @(negedge clk);
      req_valid = '0;
      repeat (20) @(negedge clk);
      #2;
      while (rsp_q.size() > 0 && expq.size() > 0) begin
        r = rsp_q.pop_front();
        e = expq.pop_front();
        chk("rand_tail_onehot", r.v, e.v);
        chk("rand_tail_quotient", r.q, e.q);
        chk("rand_tail_err", r.e, e.e);
      end
      chk("rand_all_answered", expq.size(), 0);
      chk("rand_no_extra_rsp", rsp_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares one non-restoring divider core among `N_REQ` requesters. Arbitration is round-robin. The block accepts one request at a time, sequences the divider through its start/stop handshake, and returns the quotient and remainder to the winning requester. It also catches divide-by-zero without starting the core, and aborts a hung core with a watchdog. It sits between the client blocks and the divider top level.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters; must be ≥2.
- `WIDTH`, 8: operand and result width; must match the divider core.
- `TIMEOUT`, 64: maximum WAIT cycles before abort; must be ≥1.

Ports:
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  N_REQ: per-requester request.
- `req_ready`  out  N_REQ: one-hot accept; at most one bit high.
- `req_dividend`  in  N_REQ*WIDTH: packed dividends; slice i belongs to requester i.
- `req_divisor`  in  N_REQ*WIDTH: packed divisors.
- `rsp_valid`  out  N_REQ: one-hot, one-cycle response pulse.
- `rsp_quotient`  out  WIDTH: quotient; valid while any `rsp_valid` bit is high.
- `rsp_remainder`  out  WIDTH: remainder; valid while any `rsp_valid` bit is high.
- `rsp_err`  out  1: error flag qualified by `rsp_valid`; set for divide-by-zero or timeout.
- `div_rst_n`  out  1: active-low reset to the divider core.
- `div_start`  out  1: one-cycle start pulse to the divider.
- `div_dividend`, `div_divisor`  out  WIDTH: latched operands, held stable from START through WAIT.
- `div_stop`  in  1: divider done pulse.
- `div_quotient`, `div_remainder`  in  WIDTH: divider results, sampled in the `div_stop` cycle.

## Operation

State machine states: IDLE, START, WAIT, ABORT, RESPOND.

- **IDLE**
  - Grant goes to the first asserted `req_valid` at or after pointer `ptr`, wrapping.
  - `req_ready[g]` is high in the same cycle (combinational from state and `req_valid`).
  - On the grant: latch `g` and both operand slices, then go to START.
  - With no `req_valid` bit high, stay in IDLE.
- **START**
  - Divisor == 0: set `err`, quotient = all-ones, remainder = dividend, go to RESPOND. `div_start` is not asserted.
  - Otherwise: `div_start`=1 for this cycle, clear the watchdog counter, go to WAIT.
- **WAIT**
  - Counter increments every cycle.
  - On `div_stop`: capture quotient and remainder, `err`=0, go to RESPOND.
  - Else, when the counter reaches `TIMEOUT`: go to ABORT.
  - `div_stop` and timeout in the same cycle: `div_stop` wins.
- **ABORT**
  - `div_rst_n`=0 for this one cycle.
  - `err`=1, quotient = 0, remainder = 0; go to RESPOND.
- **RESPOND**
  - `rsp_valid[g]`=1 with the registered results.
  - `ptr` ← (g+1) mod `N_REQ`; go to IDLE.

General rules:
- Requesters hold `req_valid` and their operands stable until `req_ready`. A `req_valid` dropped before grant is simply not served.
- `div_stop` outside WAIT is ignored.
- Only one transaction is in flight at a time; there is no queueing.

## Timing

- Reset values:
  - state=IDLE, `ptr`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_quotient`=0, `rsp_remainder`=0.
  - `div_start`=0, `div_dividend`=0, `div_divisor`=0.
  - `div_rst_n`=0 for as long as `rst` is high.
- Handshake latency (request accepted in cycle T):
  - `div_start` at T+1.
  - If `div_stop` arrives at cycle S, `rsp_valid` is at S+1.
  - Divide-by-zero: `rsp_valid` at T+2.
  - Timeout: ABORT at T+2+`TIMEOUT`, `rsp_valid` one cycle later.
- Back-to-back: the next grant can occur in the cycle after RESPOND.
- Reset mid-operation: the next cycle is IDLE with no `rsp_valid`. The in-flight request is dropped, and the divider is held in reset by `div_rst_n`.
- Results are registered; `rsp_*` outputs are glitch-free.

## Structure

- Package `div_pkg`:
  - `arb_state_t` enum (4-bit).
  - Default `WIDTH` and `TIMEOUT` constants.
  - Zero-divisor result constants.
- Sub-module `div_rr_pick`: purely combinational round-robin picker.
  - Inputs: `req_valid`, `ptr`.
  - Outputs: one-hot grant, grant index, `any`.
- The FSM, watchdog counter and result registers live in `div_arbiter`.

## Test plan

- **Single request.** Req1 issues 100/7. Expect:
  - `div_start` one cycle after the grant.
  - `rsp_valid`=0010, quotient 14, remainder 2, `rsp_err`=0.
- **Round-robin fairness.** All four `req_valid` held high from `ptr`=0. Expect grants in order 0,1,2,3,0 with correct per-requester results.
- **Divide-by-zero.** Req2 issues 55/0. Expect:
  - No `div_start`.
  - `rsp_valid`=0100 at T+2, quotient 0xFF, remainder 55, `rsp_err`=1.
- **Timeout.** Divider model never pulses `div_stop`, `TIMEOUT`=64. Expect:
  - `div_rst_n` low for one cycle at T+66.
  - `rsp_err`=1 with zero results, then the next request is served normally.
- **Reset mid-WAIT.** Assert `rst` during WAIT. Expect:
  - No `rsp_valid`, `ptr`=0, `div_rst_n` low.
  - A fresh request from req3 completes correctly.
- **Stop/timeout collision.** `div_stop` in the same cycle the counter hits `TIMEOUT`. Expect valid results with `rsp_err`=0.
